// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Round-robin sharing of the single register-file read port between N_REQ
//   requesters. Stage 1 registers the grant and the mux select. Stage 2
//   captures the mux output and tags it with the id of the granted requester.
//   Optional feature: define REGFILE_ARB_FORWARD_EN to enable write-through
//   forwarding of a same-cycle register-file write into the captured response.
module regfile_read_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]       rf_sel,
   input  logic [DATA_W-1:0]       rf_rdata,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_data,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data
);

   localparam logic [ID_W:0]   NREQ_C = (ID_W+1)'(N_REQ);
   localparam logic [ID_W-1:0] LAST_C = ID_W'(N_REQ - 1);

   logic [N_REQ-1:0]   elig;
   logic [2*N_REQ-1:0] elig_dbl;
   logic [N_REQ-1:0]   elig_rot;
   logic [N_REQ-1:0]   bit_probe;
   logic               found;
   logic [ID_W:0]      off;
   logic [ID_W:0]      sum;
   logic [ID_W-1:0]    win;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    id_q;
   logic               issue_q;

   // Winner selection: rotate the eligible set so rr_ptr sits at bit 0, take
   // the lowest set bit, then rotate the offset back into a requester index.
   always_comb begin
      elig      = req & ~gnt;
      elig_dbl  = {elig, elig};
      elig_rot  = N_REQ'(elig_dbl >> rr_ptr);
      found     = 1'b0;
      off       = '0;
      bit_probe = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         bit_probe = elig_rot >> k;
         if (!found && bit_probe[0]) begin
            found = 1'b1;
            off   = (ID_W+1)'(k);
         end
      end
      sum = {1'b0, rr_ptr} + off;
      if (sum >= NREQ_C) begin
         sum = sum - NREQ_C;
      end
      win = sum[ID_W-1:0];
   end

   // Stage 1: register grant, mux select, owner id and round-robin pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt     <= '0;
         rf_sel  <= '0;
         id_q    <= '0;
         issue_q <= 1'b0;
         rr_ptr  <= '0;
      end else if (found) begin
         gnt     <= N_REQ'(1) << win;
         rf_sel  <= ADDR_W'(req_addr >> (win * ADDR_W));
         id_q    <= win;
         issue_q <= 1'b1;
         rr_ptr  <= (win == LAST_C) ? '0 : win + ID_W'(1);
      end else begin
         gnt     <= '0;
         issue_q <= 1'b0;
      end
   end

   // Stage 2: capture read data for the read issued on the previous edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else if (issue_q) begin
         rsp_valid <= 1'b1;
         rsp_id    <= id_q;
`ifdef REGFILE_ARB_FORWARD_EN
         rsp_data  <= (wr_en && (wr_addr == rf_sel)) ? wr_data : rf_rdata;
`else
         rsp_data  <= rf_rdata;
`endif
      end else begin
         rsp_valid <= 1'b0;
      end
   end

`ifndef REGFILE_ARB_FORWARD_EN
   // Write port is only observed when forwarding is compiled in.
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter
//   Vector table of per-cycle stimulus and expected grants; expected responses
//   are queued on each expected grant and checked the following cycle.
//   Register-file model: register k reads back value k.
module tb_regfile_read_arbiter;

`ifdef REGFILE_ARB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [19:0] req_addr = '0;
   logic [3:0]  gnt;
   logic [4:0]  rf_sel;
   logic [31:0] rf_rdata;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [31:0] rsp_data;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [19:0] addr;
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [31:0] wr_data;
      logic [3:0]  exp_gnt;
   } rec_t;

   typedef struct {
      logic [1:0] id;
      logic [4:0] addr;
   } exp_t;

   exp_t sb[$];
   rec_t vec[25];

   always #5 clk = ~clk;

   assign rf_rdata = {27'd0, rf_sel};

   regfile_read_arbiter #(
      .N_REQ (4),
      .ADDR_W(5),
      .DATA_W(32),
      .ID_W  (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_addr (req_addr),
      .gnt      (gnt),
      .rf_sel   (rf_sel),
      .rf_rdata (rf_rdata),
      .rsp_valid(rsp_valid),
      .rsp_id   (rsp_id),
      .rsp_data (rsp_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic rec_t mk(input logic rst, input logic [3:0] rq, input logic [19:0] a,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [3:0] eg);
      rec_t r;
      r.rst = rst; r.req = rq; r.addr = a; r.wr_en = we;
      r.wr_addr = wa; r.wr_data = wd; r.exp_gnt = eg;
      return r;
   endfunction

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Apply one cycle of stimulus and check both the grant and any due response.
   task automatic apply(input rec_t r, input int row);
      exp_t        it;
      logic [19:0] sh;
      logic [31:0] exp_data;
      @(negedge clk);
      reset    = r.rst;
      req      = r.req;
      req_addr = r.addr;
      wr_en    = r.wr_en;
      wr_addr  = r.wr_addr;
      wr_data  = r.wr_data;
      @(posedge clk);
      #1;
      if (r.rst) begin
         sb.delete();
         chk($sformatf("row%0d reset gnt", row), 32'(gnt), 32'h0);
         chk($sformatf("row%0d reset rsp_valid", row), 32'(rsp_valid), 32'h0);
         chk($sformatf("row%0d reset rsp_data", row), rsp_data, 32'h0);
         chk($sformatf("row%0d reset rsp_id", row), 32'(rsp_id), 32'h0);
         chk($sformatf("row%0d reset rf_sel", row), 32'(rf_sel), 32'h0);
      end else begin
         if (sb.size() > 0) begin
            it = sb.pop_front();
            exp_data = {27'd0, it.addr};
            if (FWD && r.wr_en && (r.wr_addr == it.addr)) exp_data = r.wr_data;
            chk($sformatf("row%0d rsp_valid", row), 32'(rsp_valid), 32'h1);
            chk($sformatf("row%0d rsp_id", row), 32'(rsp_id), 32'(it.id));
            chk($sformatf("row%0d rsp_data", row), rsp_data, exp_data);
         end else begin
            chk($sformatf("row%0d rsp_valid idle", row), 32'(rsp_valid), 32'h0);
         end
         chk($sformatf("row%0d gnt", row), 32'(gnt), 32'(r.exp_gnt));
         if (r.exp_gnt != 4'b0000) begin
            it.id = oh2idx(r.exp_gnt);
            sh = r.addr >> (32'(it.id) * 5);
            it.addr = sh[4:0];
            sb.push_back(it);
         end
      end
   endtask

   initial begin
      logic [19:0] a_rr, a_17, a_31, a_5;
      a_rr = {5'd11, 5'd10, 5'd9, 5'd8};
      a_17 = {5'd11, 5'd17, 5'd9, 5'd8};
      a_31 = {5'd11, 5'd17, 5'd9, 5'd31};
      a_5  = {5'd5,  5'd17, 5'd9, 5'd31};

      // reset held with all requests pending, then round-robin rotation
      vec[0]  = mk(1, 4'b1111, a_rr, 0, 5'd0, 32'h0, 4'b0000);
      vec[1]  = mk(1, 4'b1111, a_rr, 0, 5'd0, 32'h0, 4'b0000);
      vec[2]  = mk(1, 4'b1111, a_rr, 0, 5'd0, 32'h0, 4'b0000);
      vec[3]  = mk(0, 4'b1111, a_rr, 0, 5'd0, 32'h0, 4'b0001);
      vec[4]  = mk(0, 4'b1111, a_rr, 0, 5'd0, 32'h0, 4'b0010);
      vec[5]  = mk(0, 4'b1111, a_rr, 0, 5'd0, 32'h0, 4'b0100);
      vec[6]  = mk(0, 4'b1111, a_rr, 0, 5'd0, 32'h0, 4'b1000);
      vec[7]  = mk(0, 4'b1111, a_rr, 0, 5'd0, 32'h0, 4'b0001);
      vec[8]  = mk(0, 4'b0000, a_rr, 0, 5'd0, 32'h0, 4'b0000);
      // single request from requester 2
      vec[9]  = mk(0, 4'b0100, a_17, 0, 5'd0, 32'h0, 4'b0100);
      vec[10] = mk(0, 4'b0000, a_17, 0, 5'd0, 32'h0, 4'b0000);
      vec[11] = mk(0, 4'b0000, a_17, 0, 5'd0, 32'h0, 4'b0000);
      // requester 0 alone, held: granted every other cycle
      vec[12] = mk(0, 4'b0001, a_31, 0, 5'd0, 32'h0, 4'b0001);
      vec[13] = mk(0, 4'b0001, a_31, 0, 5'd0, 32'h0, 4'b0000);
      vec[14] = mk(0, 4'b0001, a_31, 0, 5'd0, 32'h0, 4'b0001);
      vec[15] = mk(0, 4'b0000, a_31, 0, 5'd0, 32'h0, 4'b0000);
      vec[16] = mk(0, 4'b0000, a_31, 0, 5'd0, 32'h0, 4'b0000);
      // same-cycle write in stage 2: matching and non-matching address
      vec[17] = mk(0, 4'b1000, a_5, 0, 5'd0, 32'h0, 4'b1000);
      vec[18] = mk(0, 4'b0000, a_5, 1, 5'd5, 32'hDEAD_BEEF, 4'b0000);
      vec[19] = mk(0, 4'b1000, a_5, 0, 5'd0, 32'h0, 4'b1000);
      vec[20] = mk(0, 4'b0000, a_5, 1, 5'd6, 32'h1234_5678, 4'b0000);
      // two requesters, the later one held across the other's grant
      vec[21] = mk(0, 4'b0101, a_5, 0, 5'd0, 32'h0, 4'b0001);
      vec[22] = mk(0, 4'b0100, a_5, 0, 5'd0, 32'h0, 4'b0100);
      vec[23] = mk(0, 4'b0000, a_5, 0, 5'd0, 32'h0, 4'b0000);
      vec[24] = mk(0, 4'b0000, a_5, 0, 5'd0, 32'h0, 4'b0000);

      for (int i = 0; i < 25; i++) begin
         apply(vec[i], i);
      end

      // reset pulsed between grant and response: read dropped, pointer back to 0
      @(negedge clk);
      req      = 4'b0010;
      req_addr = a_5;
      wr_en    = 1'b0;
      @(posedge clk);
      #1;
      chk("t5 gnt before pulse", 32'(gnt), 32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk("t5 async gnt clear", 32'(gnt), 32'h0);
      chk("t5 async rf_sel clear", 32'(rf_sel), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      req   = 4'b1111;
      sb.delete();
      @(posedge clk);
      #1;
      chk("t5 no rsp after reset", 32'(rsp_valid), 32'h0);
      chk("t5 rr restart gnt", 32'(gnt), 32'h1);
      sb.push_back('{id: 2'd0, addr: 5'd31});
      apply(mk(0, 4'b0000, a_5, 0, 5'd0, 32'h0, 4'b0000), 100);
      apply(mk(0, 4'b0000, a_5, 0, 5'd0, 32'h0, 4'b0000), 101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
